// File: rtl/jtkcpu_stkseq.sv
// Push/pull stack sequencer: walks a register mask one byte per step, emitting select/byte/strobe/SP-step.
// Latency: first byte is presented the cycle after an accepted go; DONE follows the last accepted byte.
// Backpressure: mem_rdy=0 or cen=0 while busy freezes every output and suppresses the SP step.
module jtkcpu_stkseq #(
    parameter int              NREG = 8,
    parameter logic [NREG-1:0] WIDE = 8'hF0,
    parameter int              SELW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic            psh_go,
    input  logic            pul_go,
    input  logic [NREG-1:0] mask,
    input  logic            us_in,
    input  logic            mem_rdy,
    output logic            busy,
    output logic            idle,
    output logic            done,
    output logic [SELW-1:0] reg_sel,
    output logic            hi_lon,
    output logic            wr_en,
    output logic            rd_en,
    output logic            sp_dec,
    output logic            sp_inc,
    output logic            us_sel,
    output logic [4:0]      bytes_left
);

    // The byte counter is 5 bits wide; a full mask must fit in it.
    localparam int MAXB = NREG + $countones(WIDE);
    if (MAXB > 31) begin : g_size_chk
        $error("jtkcpu_stkseq: NREG + popcount(WIDE) exceeds 31 bytes");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [NREG-1:0] rem;        // registers not yet fully transferred
    logic            push_q;     // 1 = push sequence, 0 = pull
    logic [4:0]      cnt;        // bytes remaining including the current one

    logic            go_any;
    logic            adv;
    logic            pair_first;
    logic [NREG-1:0] rem_clr;
    logic [SELW-1:0] sel_nx;
    logic [SELW-1:0] first_sel;
    logic [4:0]      mask_bytes;

    // Highest set bit of a mask (push walks downward).
    function automatic logic [SELW-1:0] msb_idx(input logic [NREG-1:0] v);
        logic [SELW-1:0] r;
        r = '0;
        for (int i = 0; i < NREG; i++) begin
            if (v[i]) r = SELW'(i);
        end
        return r;
    endfunction

    // Lowest set bit of a mask (pull walks upward).
    function automatic logic [SELW-1:0] lsb_idx(input logic [NREG-1:0] v);
        logic [SELW-1:0] r;
        r = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (v[i]) r = SELW'(i);
        end
        return r;
    endfunction

    assign busy   = (state == S_STEP);
    assign idle   = (state == S_IDLE);
    assign done   = (state == S_DONE);
    assign go_any = psh_go | pul_go;
    assign adv    = cen & mem_rdy & busy;

    assign wr_en      = busy & push_q;
    assign rd_en      = busy & ~push_q;
    assign sp_dec     = adv & push_q;
    assign sp_inc     = adv & ~push_q;
    assign bytes_left = busy ? cnt : 5'd0;

    // Step bookkeeping: a 16-bit register takes two steps before its mask bit is retired.
    always_comb begin
        pair_first = WIDE[reg_sel] & (push_q ? ~hi_lon : hi_lon);
        rem_clr    = rem & ~({{(NREG-1){1'b0}}, 1'b1} << reg_sel);
        sel_nx     = push_q ? msb_idx(rem_clr) : lsb_idx(rem_clr);
        first_sel  = psh_go ? msb_idx(mask) : lsb_idx(mask);
        mask_bytes = 5'($countones(mask)) + 5'($countones(mask & WIDE));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic: an empty mask skips straight to DONE.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (cen && go_any)            state_nx = (mask != '0) ? S_STEP : S_DONE;
            S_STEP: if (adv && cnt == 5'd1)       state_nx = S_DONE;
            S_DONE: if (cen)                      state_nx = S_IDLE;
            default:                              state_nx = S_IDLE;
        endcase
    end

    // Datapath: latch the request on go, then present the next byte on each advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem     <= '0;
            push_q  <= 1'b0;
            us_sel  <= 1'b0;
            reg_sel <= '0;
            hi_lon  <= 1'b0;
            cnt     <= 5'd0;
        end else if (idle && cen && go_any) begin
            rem     <= mask;
            push_q  <= psh_go;
            us_sel  <= us_in;
            reg_sel <= first_sel;
            // Pull sends the high byte of a 16-bit register first.
            hi_lon  <= ~psh_go & WIDE[first_sel] & (mask != '0);
            cnt     <= mask_bytes;
        end else if (adv) begin
            if (cnt == 5'd1) begin
                rem     <= '0;
                reg_sel <= '0;
                hi_lon  <= 1'b0;
                cnt     <= 5'd0;
            end else if (pair_first) begin
                hi_lon  <= ~hi_lon;
                cnt     <= cnt - 5'd1;
            end else begin
                rem     <= rem_clr;
                reg_sel <= sel_nx;
                hi_lon  <= ~push_q & WIDE[sel_nx];
                cnt     <= cnt - 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_jtkcpu_stkseq.sv
// Bench for jtkcpu_stkseq: table of go requests, per-byte scoreboard built from the register map.
// Inputs change on the falling edge; outputs are sampled 1 ns later, before the next rising edge.
// Stalls via mem_rdy or cen, go arbitration and a mid-sequence reset are table options.
module tb_jtkcpu_stkseq;

    localparam logic [7:0] WIDE_TB = 8'hF0;

    logic       clk = 1'b0;
    logic       rst, cen, psh_go, pul_go, us_in, mem_rdy;
    logic [7:0] mask;
    logic       busy, idle, done, hi_lon, wr_en, rd_en, sp_dec, sp_inc, us_sel;
    logic [2:0] reg_sel;
    logic [4:0] bytes_left;

    jtkcpu_stkseq dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .psh_go     (psh_go),
        .pul_go     (pul_go),
        .mask       (mask),
        .us_in      (us_in),
        .mem_rdy    (mem_rdy),
        .busy       (busy),
        .idle       (idle),
        .done       (done),
        .reg_sel    (reg_sel),
        .hi_lon     (hi_lon),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .sp_dec     (sp_dec),
        .sp_inc     (sp_inc),
        .us_sel     (us_sel),
        .bytes_left (bytes_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        logic       hi;
        int         left;
    } byte_t;

    typedef struct {
        logic       pg;
        logic       ug;
        logic [7:0] m;
        logic       us;
        int         stall;
        logic       stall_cen;
        logic       inj;
        int         abort_at;
        int         nbytes;
    } vec_t;

    byte_t q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Expected byte stream, derived directly from the register map.
    task automatic build(input logic psh, input logic [7:0] m);
        byte_t b;
        int    tot;
        q.delete();
        b.left = 0;
        if (psh) begin
            for (int i = 7; i >= 0; i--) begin
                if (m[i]) begin
                    b.sel = 3'(i); b.hi = 1'b0; q.push_back(b);
                    if (WIDE_TB[i]) begin b.hi = 1'b1; q.push_back(b); end
                end
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (m[i]) begin
                    if (WIDE_TB[i]) begin b.sel = 3'(i); b.hi = 1'b1; q.push_back(b); end
                    b.sel = 3'(i); b.hi = 1'b0; q.push_back(b);
                end
            end
        end
        tot = q.size();
        for (int k = 0; k < tot; k++) q[k].left = tot - k;
    endtask

    task automatic run(input vec_t v, input string nm);
        byte_t e;
        int    cyc, nb, stall;
        logic  psh;
        psh   = v.pg;              // push wins when both requests are high
        stall = v.stall;
        build(psh, v.m);
        chk({nm, " idle_before"}, int'(idle), 1);
        psh_go = v.pg; pul_go = v.ug; mask = v.m; us_in = v.us; mem_rdy = 1'b1; cen = 1'b1;
        @(negedge clk);
        psh_go = 1'b0; pul_go = 1'b0; mask = 8'($urandom);
        cyc = 0; nb = 0;
        while (!done && cyc < 200) begin
            if (!busy) begin
                chk({nm, " busy"}, int'(busy), 1);
                break;
            end
            pul_go = v.inj;
            if (stall > 0) begin
                if (v.stall_cen) cen = 1'b0; else mem_rdy = 1'b0;
            end else begin
                cen = 1'b1; mem_rdy = 1'b1;
            end
            #1;
            if (q.size() == 0) begin
                chk({nm, " extra_byte"}, 1, 0);
                break;
            end
            e = q[0];
            chk({nm, " reg_sel"},    int'(reg_sel),    int'(e.sel));
            chk({nm, " hi_lon"},     int'(hi_lon),     int'(e.hi));
            chk({nm, " bytes_left"}, int'(bytes_left), e.left);
            chk({nm, " wr_en"},      int'(wr_en),      int'(psh));
            chk({nm, " rd_en"},      int'(rd_en),      int'(!psh));
            if (stall > 0) begin
                chk({nm, " sp_step_stalled"}, int'(sp_dec | sp_inc), 0);
                stall--;
            end else begin
                void'(q.pop_front());
                chk({nm, " sp_dec"}, int'(sp_dec), int'(psh));
                chk({nm, " sp_inc"}, int'(sp_inc), int'(!psh));
                chk({nm, " us_sel"}, int'(us_sel), int'(v.us));
                if (nb == 0) chk({nm, " first_left"}, int'(bytes_left), v.nbytes);
                nb++;
                if (v.abort_at >= 0 && nb == v.abort_at + 1) begin
                    rst = 1'b1;
                    @(negedge clk);
                    #1;
                    chk({nm, " abort_idle"},   int'(idle),       1);
                    chk({nm, " abort_busy"},   int'(busy),       0);
                    chk({nm, " abort_strobe"}, int'({wr_en, rd_en, sp_dec, sp_inc}), 0);
                    chk({nm, " abort_left"},   int'(bytes_left), 0);
                    rst = 1'b0; pul_go = 1'b0; cen = 1'b1; mem_rdy = 1'b1;
                    q.delete();
                    @(negedge clk);
                    return;
                end
            end
            @(negedge clk);
            cyc++;
        end
        pul_go = 1'b0; cen = 1'b1; mem_rdy = 1'b1;
        chk({nm, " done"},        int'(done),   1);
        chk({nm, " step_cycles"}, cyc,          v.nbytes + v.stall);
        chk({nm, " leftover"},    q.size(),     0);
        chk({nm, " done_strobe"}, int'({wr_en, rd_en, busy}), 0);
        @(negedge clk);
        chk({nm, " idle_after"},  int'(idle),   1);
        chk({nm, " done_pulse"},  int'(done),   0);
        chk({nm, " us_kept"},     int'(us_sel), int'(v.us));
    endtask

    vec_t tbl[11];

    initial begin
        //            pg    ug    mask   us    stall cen   inj   abort nbytes
        tbl[0]  = '{1'b1, 1'b0, 8'hFF, 1'b0, 0, 1'b0, 1'b0, -1, 12};
        tbl[1]  = '{1'b0, 1'b1, 8'h81, 1'b1, 0, 1'b0, 1'b0, -1,  3};
        tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0, -1,  0};
        tbl[3]  = '{1'b0, 1'b1, 8'h06, 1'b0, 3, 1'b0, 1'b0, -1,  2};
        tbl[4]  = '{1'b1, 1'b1, 8'h01, 1'b1, 0, 1'b0, 1'b1, -1,  1};
        tbl[5]  = '{1'b1, 1'b0, 8'hFF, 1'b0, 0, 1'b0, 1'b0,  4, 12};
        tbl[6]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 0, 1'b0, 1'b0, -1,  6};
        tbl[7]  = '{1'b1, 1'b0, 8'hF0, 1'b0, 2, 1'b1, 1'b0, -1,  8};
        tbl[8]  = '{1'b0, 1'b1, 8'h0F, 1'b0, 0, 1'b0, 1'b0, -1,  4};
        tbl[9]  = '{1'b1, 1'b0, 8'h55, 1'b1, 0, 1'b0, 1'b0, -1,  6};
        tbl[10] = '{1'b0, 1'b1, 8'hAA, 1'b0, 0, 1'b0, 1'b0, -1,  6};

        rst = 1'b1; cen = 1'b1; psh_go = 1'b0; pul_go = 1'b0;
        mask = 8'h00; us_in = 1'b0; mem_rdy = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst idle",       int'(idle),       1);
        chk("rst busy",       int'(busy),       0);
        chk("rst done",       int'(done),       0);
        chk("rst strobes",    int'({wr_en, rd_en, sp_dec, sp_inc, hi_lon}), 0);
        chk("rst reg_sel",    int'(reg_sel),    0);
        chk("rst us_sel",     int'(us_sel),     0);
        chk("rst bytes_left", int'(bytes_left), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run(tbl[i], $sformatf("vec%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
